wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the single-issue RV32I core. Takes retiring instructions from the memory stage, selects the result source, and formats load data (byte/halfword extract, sign/zero extend). Waits a variable number of cycles for the data-memory read response. Drives the register file write port `WE3`/`A3`/`WD3` from registers, and exposes the pending load destination to the hazard unit for load-use stalls.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `MEM_TIMEOUT`, 15, maximum cycles to wait for `mem_rvalid` before error; range 1–255

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  memory stage presents a retiring instruction
- `in_ready`  out  1  stage can accept; combinational, = (state != WAIT_MEM)
- `in_rd_we`  in  1  instruction writes `rd`
- `in_rd`  in  5  destination register
- `in_wb_sel`  in  2  result source: 0 ALU, 1 MEM, 2 PC4, 3 IMM
- `in_alu_res`, `in_pc4`, `in_imm`  in  XLEN  result candidates
- `in_funct3`  in  3  load type (used only when `in_wb_sel`=MEM)
- `in_addr_lo`  in  2  load byte address bits [1:0]
- `mem_rvalid`  in  1  read-data response valid
- `mem_rdata`  in  XLEN  read word, naturally aligned
- `WE3`  out  1  register file write enable, registered
- `A3`  out  5  register file write address, registered
- `WD3`  out  XLEN  register file write data, registered
- `pend_valid`  out  1  a load is outstanding (= state WAIT_MEM)
- `pend_rd`  out  5  `rd` of the outstanding load
- `err`  out  1  one-cycle pulse on misaligned access, illegal load type, or timeout

## Operation
- FSM states: IDLE, WAIT_MEM. Reset state: IDLE.
- **Accept** = `in_valid` && `in_ready`.
- **IDLE, accept, `in_wb_sel`≠MEM:**
  - Next cycle: `WE3`=`in_rd_we` && (`in_rd`≠0), `A3`=`in_rd`, `WD3`=selected source.
  - State stays IDLE.
- **IDLE, accept, `in_wb_sel`=MEM, legal and aligned:**
  - Latch `rd`, `rd_we`, `funct3`, `addr_lo`.
  - Clear the timeout counter.
  - Go to WAIT_MEM.
  - `WE3`=0 next cycle.
- **Legal loads:**
  - 000 LB: sign-extend byte `addr_lo`.
  - 001 LH: sign-extend half `addr_lo[1]`.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
- **Illegal funct3** (011, 110, 111), or misaligned access (LH/LHU with `addr_lo[0]`=1; LW with `addr_lo`≠0):
  - `err`=1 next cycle.
  - No write; stay IDLE.
  - Upstream issues no memory request for these.
- **WAIT_MEM, `mem_rvalid`=1:**
  - Next cycle: `WE3`=latched `rd_we` && `rd`≠0, `A3`=latched `rd`, `WD3`=formatted data.
  - Go to IDLE.
- **WAIT_MEM, `mem_rvalid`=0:**
  - Counter increments.
  - When it reaches `MEM_TIMEOUT`: `err` pulse, go to IDLE, no write.
- `mem_rvalid` while IDLE is stray and is ignored.
- Writes to x0 are always suppressed (`WE3`=0); `A3`/`WD3` still update.

## Timing
- Reset values: `WE3`=0, `A3`=0, `WD3`=0, `err`=0. `pend_valid`=0 and `pend_rd`=0. Counter=0, state IDLE.
- `in_ready`=1 out of reset.
- **Non-load latency:** accept in cycle N → `WE3` high in N+1 for one cycle. Back-to-back accepts give back-to-back writes (full throughput).
- **Load latency:**
  - Load accepted in N. `pend_valid`=1 from N+1 until the cycle the response arrives, inclusive.
  - `mem_rvalid` in cycle M (M ≥ N+1) → write in M+1.
  - `mem_rvalid` in cycle N itself is not counted.
- **Timeout:** with no response, `err`=1 in cycle N+1+`MEM_TIMEOUT`.
  - `in_ready` returns to 1 in that same cycle.
  - If `mem_rvalid` arrives in the final waiting cycle, the response wins and no error is raised.
- **In the cycle the response arrives:**
  - `in_ready` stays 0.
  - A new instruction can be accepted in M+1, concurrently with the load's write.
- `in_valid` must be held until accept; inputs are sampled only on accept.
- **Reset mid-load:** state goes to IDLE and all outputs clear immediately (asynchronous). The abandoned response arriving later is ignored as stray.

## Structure
- Package `wb_pkg`:
  - `wb_sel_e` enum (ALU, MEM, PC4, IMM)
  - load `funct3` constants (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`)
  - `wb_state_e` enum
  - `XLEN` default
- One combinational sub-module, `load_align`. Inputs: `funct3`, `addr_lo`, `rdata`. Outputs: `data`, `illegal`.
  - `illegal` covers both illegal type and misalignment.
  - Used both at accept (legality check) and at response (formatting).

## Test plan
- **ALU write:**
  - Stimulus: accept `in_wb_sel`=0, `rd`=5, `alu`=0x1234_5678.
  - Response: next cycle `WE3`=1, `A3`=5, `WD3`=0x1234_5678; then `WE3`=0.
- **x0 suppression:** accept `in_wb_sel`=2, `rd`=0, `pc4`=0x100 → `WE3`=0, `A3`=0, `WD3`=0x100.
- **Load formatting:**
  - LB, `addr_lo`=3, `rdata`=0x80FF_0011, 2-cycle wait → `WD3`=0xFFFF_FF80.
  - LHU, `addr_lo`=2, same `rdata` → `WD3`=0x0000_80FF.
  - Check `pend_valid`/`pend_rd` during the wait.
- **Misaligned/illegal:**
  - LW with `addr_lo`=1 → `err` pulse next cycle, no write, `in_ready` stays 1.
  - `funct3`=011 → same behaviour.
- **Timeout:** with `MEM_TIMEOUT`=4, issue a load and never assert `mem_rvalid`.
  - Required: `err` in N+5, no write.
  - A later stray `mem_rvalid` causes no write.
- **Reset mid-load and back-to-back:**
  - Assert `rst` in WAIT_MEM → `WE3`/`pend_valid` drop immediately.
  - After release: three consecutive ALU accepts → three consecutive writes.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the RV32I write-back stage.
package wb_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// Memory-stage handshake, data-memory response and register-file write port.
interface wb_stage_if
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);
  logic            in_valid;
  logic            in_ready;
  logic            in_rd_we;
  logic [4:0]      in_rd;
  wb_sel_e         in_wb_sel;
  logic [XLEN-1:0] in_alu_res;
  logic [XLEN-1:0] in_pc4;
  logic [XLEN-1:0] in_imm;
  logic [2:0]      in_funct3;
  logic [1:0]      in_addr_lo;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            WE3;
  logic [4:0]      A3;
  logic [XLEN-1:0] WD3;
  logic            pend_valid;
  logic [4:0]      pend_rd;
  logic            err;

  modport master (
    output in_valid, in_rd_we, in_rd, in_wb_sel, in_alu_res, in_pc4, in_imm,
           in_funct3, in_addr_lo, mem_rvalid, mem_rdata,
    input  in_ready, WE3, A3, WD3, pend_valid, pend_rd, err
  );

  modport slave (
    input  in_valid, in_rd_we, in_rd, in_wb_sel, in_alu_res, in_pc4, in_imm,
           in_funct3, in_addr_lo, mem_rvalid, mem_rdata,
    output in_ready, WE3, A3, WD3, pend_valid, pend_rd, err
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// Load data extraction/extension plus legality (type and alignment) check.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            illegal
);
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = rdata[{addr_lo, 3'b000} +: 8];
  assign half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data    = '0;
    illegal = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_s[7]}}, byte_s};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_s};
      F3_LH: begin
        data    = {{(XLEN-16){half_s[15]}}, half_s};
        illegal = addr_lo[0];
      end
      F3_LHU: begin
        data    = {{(XLEN-16){1'b0}}, half_s};
        illegal = addr_lo[0];
      end
      F3_LW: begin
        data    = rdata;
        illegal = (addr_lo != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// Write-back stage: result select, load wait/format, registered regfile write.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN        = XLEN_DEFAULT,
  parameter int MEM_TIMEOUT = 15
) (
  input logic       clk,
  input logic       rst,
  wb_stage_if.slave bus
);
  wb_state_e       state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [4:0]      rd_q, rd_d;
  logic            rd_we_q, rd_we_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      alo_q, alo_d;
  logic            we3_q, we3_d;
  logic [4:0]      a3_q, a3_d;
  logic [XLEN-1:0] wd3_q, wd3_d;
  logic            err_q, err_d;

  logic            accept;
  logic [2:0]      la_f3;
  logic [1:0]      la_alo;
  logic [XLEN-1:0] la_data;
  logic            la_illegal;

  assign bus.in_ready   = (state_q != S_WAIT_MEM);
  assign accept         = bus.in_valid && bus.in_ready;
  assign bus.WE3        = we3_q;
  assign bus.A3         = a3_q;
  assign bus.WD3        = wd3_q;
  assign bus.err        = err_q;
  assign bus.pend_valid = (state_q == S_WAIT_MEM);
  assign bus.pend_rd    = (state_q == S_WAIT_MEM) ? rd_q : 5'd0;

  // One aligner serves both phases: legality of the incoming load while
  // idle, formatting of the latched load while waiting for the response.
  assign la_f3  = (state_q == S_WAIT_MEM) ? f3_q  : bus.in_funct3;
  assign la_alo = (state_q == S_WAIT_MEM) ? alo_q : bus.in_addr_lo;

  load_align #(.XLEN(XLEN)) u_align (
    .funct3  (la_f3),
    .addr_lo (la_alo),
    .rdata   (bus.mem_rdata),
    .data    (la_data),
    .illegal (la_illegal)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    rd_we_d = rd_we_q;
    f3_d    = f3_q;
    alo_d   = alo_q;
    we3_d   = 1'b0;
    a3_d    = a3_q;
    wd3_d   = wd3_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.in_wb_sel != WB_MEM) begin
            we3_d = bus.in_rd_we && (bus.in_rd != 5'd0);
            a3_d  = bus.in_rd;
            case (bus.in_wb_sel)
              WB_PC4:  wd3_d = bus.in_pc4;
              WB_IMM:  wd3_d = bus.in_imm;
              default: wd3_d = bus.in_alu_res;
            endcase
          end else if (la_illegal) begin
            err_d = 1'b1;
          end else begin
            rd_d    = bus.in_rd;
            rd_we_d = bus.in_rd_we;
            f3_d    = bus.in_funct3;
            alo_d   = bus.in_addr_lo;
            cnt_d   = 8'd0;
            state_d = S_WAIT_MEM;
          end
        end
      end
      S_WAIT_MEM: begin
        // A response in the last waiting cycle takes priority over timeout.
        if (bus.mem_rvalid) begin
          we3_d   = rd_we_q && (rd_q != 5'd0);
          a3_d    = rd_q;
          wd3_d   = la_data;
          state_d = S_IDLE;
        end else if (cnt_q == 8'(MEM_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      rd_we_q <= 1'b0;
      f3_q    <= '0;
      alo_q   <= '0;
      we3_q   <= 1'b0;
      a3_q    <= '0;
      wd3_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      rd_we_q <= rd_we_d;
      f3_q    <= f3_d;
      alo_q   <= alo_d;
      we3_q   <= we3_d;
      a3_q    <= a3_d;
      wd3_q   <= wd3_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus queues cycle-tagged expectations, monitor checks outputs.
module tb_wb_stage;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wb_stage_if #(.XLEN(32)) bus ();

  wb_stage #(.XLEN(32), .MEM_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          cyc;
    bit          we;
    logic [4:0]  a3;
    logic [31:0] wd3;
    bit          err;
    bit          chk_data;
    string       name;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input int off, input bit we, input logic [4:0] a3,
                      input logic [31:0] wd3, input bit er, input bit cd);
    exp_t e;
    e.cyc = cyc + off; e.we = we; e.a3 = a3; e.wd3 = wd3; e.err = er; e.chk_data = cd; e.name = name;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input wb_sel_e sel, input logic [4:0] rd, input logic we,
                       input logic [31:0] val, input logic [2:0] f3, input logic [1:0] alo);
    bus.in_valid   = 1'b1;
    bus.in_wb_sel  = sel;
    bus.in_rd      = rd;
    bus.in_rd_we   = we;
    bus.in_alu_res = val;
    bus.in_pc4     = val;
    bus.in_imm     = val;
    bus.in_funct3  = f3;
    bus.in_addr_lo = alo;
  endtask

  // Monitor: compares whenever an expectation is due or the DUT presents a write/error.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
          e = sb.pop_front();
          nvec++; nerr++;
          $display("FAIL %s: expectation for cycle %0d never checked (now %0d)", e.name, e.cyc, cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
          e = sb.pop_front();
          nvec++;
          if (bus.WE3 !== e.we || bus.err !== e.err ||
              (e.chk_data && (bus.A3 !== e.a3 || bus.WD3 !== e.wd3))) begin
            nerr++;
            $display("FAIL %s: got WE3=%b A3=%0d WD3=%h err=%b expected WE3=%b A3=%0d WD3=%h err=%b",
                     e.name, bus.WE3, bus.A3, bus.WD3, bus.err, e.we, e.a3, e.wd3, e.err);
          end
        end else if (bus.WE3 !== 1'b0 || bus.err !== 1'b0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_output: cycle %0d got WE3=%b A3=%0d WD3=%h err=%b expected WE3=0 err=0",
                   cyc, bus.WE3, bus.A3, bus.WD3, bus.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] ill_tab [3];
    logic [4:0] ill;
    ill_tab[0] = {3'b010, 2'd1};  // LW misaligned
    ill_tab[1] = {3'b011, 2'd0};  // illegal type
    ill_tab[2] = {3'b001, 2'd1};  // LH misaligned

    bus.in_valid = 1'b0; bus.in_rd_we = 1'b0; bus.in_rd = '0; bus.in_wb_sel = WB_ALU;
    bus.in_alu_res = '0; bus.in_pc4 = '0; bus.in_imm = '0; bus.in_funct3 = '0;
    bus.in_addr_lo = '0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_WE3", 32'(bus.WE3), 32'd0);
    chk("rst_A3", 32'(bus.A3), 32'd0);
    chk("rst_WD3", bus.WD3, 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_pend_valid", 32'(bus.pend_valid), 32'd0);
    chk("rst_pend_rd", 32'(bus.pend_rd), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    step();

    // ALU write, then WE3 drops
    drive(WB_ALU, 5'd5, 1'b1, 32'h1234_5678, 3'b000, 2'd0);
    push("alu_write", 1, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 1'b1);
    step();
    bus.in_valid = 1'b0;
    push("alu_we_drop", 1, 1'b0, 5'd5, 32'h1234_5678, 1'b0, 1'b1);
    step();

    // x0 suppression, address/data still update
    drive(WB_PC4, 5'd0, 1'b1, 32'h0000_0100, 3'b000, 2'd0);
    push("x0_suppress", 1, 1'b0, 5'd0, 32'h0000_0100, 1'b0, 1'b1);
    step();
    bus.in_valid = 1'b0;
    step();

    // LB addr_lo=3 with a 2-cycle wait
    drive(WB_MEM, 5'd7, 1'b1, 32'h0, F3_LB, 2'd3);
    step();
    bus.in_valid = 1'b0;
    chk("lb_pend_valid_w1", 32'(bus.pend_valid), 32'd1);
    chk("lb_pend_rd_w1", 32'(bus.pend_rd), 32'd7);
    chk("lb_in_ready_w1", 32'(bus.in_ready), 32'd0);
    step();
    chk("lb_pend_valid_resp", 32'(bus.pend_valid), 32'd1);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h80FF_0011;
    push("lb_data", 1, 1'b1, 5'd7, 32'hFFFF_FF80, 1'b0, 1'b1);
    step();
    bus.mem_rvalid = 1'b0;
    chk("lb_pend_clear", 32'(bus.pend_valid), 32'd0);
    chk("lb_in_ready_back", 32'(bus.in_ready), 32'd1);
    step();

    // LHU addr_lo=2; a response in the accept cycle itself must be ignored
    drive(WB_MEM, 5'd9, 1'b1, 32'h0, F3_LHU, 2'd2);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111_2222;
    step();
    bus.in_valid = 1'b0; bus.mem_rvalid = 1'b0;
    chk("lhu_pend_rd", 32'(bus.pend_rd), 32'd9);
    step();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h80FF_0011;
    push("lhu_data", 1, 1'b1, 5'd9, 32'h0000_80FF, 1'b0, 1'b1);
    step();
    bus.mem_rvalid = 1'b0;
    step();

    // Misaligned / illegal loads: error pulse, no write, stays ready
    for (int i = 0; i < 3; i++) begin
      ill = ill_tab[i];
      drive(WB_MEM, 5'd3, 1'b1, 32'h0, ill[4:2], ill[1:0]);
      push("illegal_load", 1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
      step();
      bus.in_valid = 1'b0;
      chk("illegal_in_ready", 32'(bus.in_ready), 32'd1);
      chk("illegal_pend_valid", 32'(bus.pend_valid), 32'd0);
      step();
    end

    // Timeout with MEM_TIMEOUT=4: err in N+5, then stray response ignored
    drive(WB_MEM, 5'd4, 1'b1, 32'h0, F3_LW, 2'd0);
    push("timeout_err", 5, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    step();
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk("timeout_in_ready_wait", 32'(bus.in_ready), 32'd0);
      step();
    end
    chk("timeout_in_ready_back", 32'(bus.in_ready), 32'd1);
    chk("timeout_pend_clear", 32'(bus.pend_valid), 32'd0);
    step();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hAAAA_5555;
    step();
    bus.mem_rvalid = 1'b0;
    step();

    // Response in the final waiting cycle wins; new accept concurrent with write
    drive(WB_MEM, 5'd6, 1'b1, 32'h0, F3_LW, 2'd0);
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    chk("last_wait_in_ready", 32'(bus.in_ready), 32'd0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    push("resp_last_cycle", 1, 1'b1, 5'd6, 32'hDEAD_BEEF, 1'b0, 1'b1);
    step();
    bus.mem_rvalid = 1'b0;
    chk("post_resp_in_ready", 32'(bus.in_ready), 32'd1);
    drive(WB_IMM, 5'd11, 1'b1, 32'h0000_0055, 3'b000, 2'd0);
    push("accept_after_resp", 1, 1'b1, 5'd11, 32'h0000_0055, 1'b0, 1'b1);
    step();
    bus.in_valid = 1'b0;
    step();

    // Reset mid-load clears outputs at once; late response is stray
    drive(WB_MEM, 5'd8, 1'b1, 32'h0, F3_LB, 2'd0);
    step();
    bus.in_valid = 1'b0;
    chk("midload_pend_valid", 32'(bus.pend_valid), 32'd1);
    chk("midload_pend_rd", 32'(bus.pend_rd), 32'd8);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_pend_valid", 32'(bus.pend_valid), 32'd0);
    chk("rst_async_pend_rd", 32'(bus.pend_rd), 32'd0);
    chk("rst_async_WE3", 32'(bus.WE3), 32'd0);
    chk("rst_async_A3", 32'(bus.A3), 32'd0);
    chk("rst_async_WD3", bus.WD3, 32'd0);
    chk("rst_async_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    rst = 1'b0;
    step();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_00FF;
    step();
    bus.mem_rvalid = 1'b0;
    step();

    // Three back-to-back ALU accepts -> three back-to-back writes
    drive(WB_ALU, 5'd1, 1'b1, 32'h0000_0001, 3'b000, 2'd0);
    push("b2b_1", 1, 1'b1, 5'd1, 32'h0000_0001, 1'b0, 1'b1);
    step();
    drive(WB_ALU, 5'd2, 1'b1, 32'h0000_0002, 3'b000, 2'd0);
    push("b2b_2", 1, 1'b1, 5'd2, 32'h0000_0002, 1'b0, 1'b1);
    step();
    drive(WB_ALU, 5'd31, 1'b1, 32'hCAFE_0003, 3'b000, 2'd0);
    push("b2b_3", 1, 1'b1, 5'd31, 32'hCAFE_0003, 1'b0, 1'b1);
    step();
    bus.in_valid = 1'b0;
    push("b2b_idle", 1, 1'b0, 5'd31, 32'hCAFE_0003, 1'b0, 1'b1);
    repeat (3) step();

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
